// File: rtl/ahb2apb_bridge_pkg.sv
// Shared AHB/APB encodings and the bridge state enumeration.
// Imported by the bridge interface and the bridge itself.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// AHB-side and APB-side signals of the bridge, bundled into one interface.
// The slave modport is the bridge's view; master is the bus/peripheral side.
interface ahb2apb_bridge_if #(
  parameter int NSLV = 4
) ();
  import ahb_apb_pkg::*;

  logic                HSEL;
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [31:0]         HWDATA;
  logic                HREADY;
  logic                HREADYOUT;
  logic [1:0]          HRESP;
  logic [31:0]         HRDATA;
  logic [NSLV-1:0]     PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [31:0]         PADDR;
  logic [31:0]         PWDATA;
  logic [32*NSLV-1:0]  PRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA,
    output HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, PRDATA,
    input  HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB slave to APB2 master bridge: one APB setup/access pair per AHB transfer,
// decoded one-hot PSEL, PRDATA mux into HRDATA, ERROR for unmapped slots.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int NSLV     = 4,
  parameter int SLV_LSB  = 12,
  parameter int SLV_BITS = 2
) (
  input logic              HCLK,
  input logic              HRST_N,
  ahb2apb_bridge_if.slave  bus
);

  bridge_state_t         state;
  logic [SLV_BITS-1:0]   slot_q;
  logic [SLV_BITS-1:0]   slot_d;
  logic                  slot_ok;
  logic                  capture;
  logic [NSLV-1:0]       psel_d;
  logic [31:0]           rdata_mux;
  logic                  unused_inputs;

  assign slot_d  = bus.HADDR[SLV_LSB +: SLV_BITS];
  assign slot_ok = {1'b0, slot_d} < (SLV_BITS+1)'(NSLV);
  // Only states that present HREADYOUT=1 can accept a new address phase.
  assign capture = (state inside {ST_IDLE, ST_RESP, ST_ERR2})
                 & bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign unused_inputs = ^{bus.HSIZE, bus.HTRANS[0]};

  always_comb begin
    psel_d    = '0;
    rdata_mux = '0;
    for (int k = 0; k < NSLV; k++) begin
      psel_d[k] = (slot_d == SLV_BITS'(k));
      if (slot_q == SLV_BITS'(k)) rdata_mux = bus.PRDATA[32*k +: 32];
    end
  end

  // PSEL is non-zero only during SETUP/ACCESS, so this also gates PWDATA to the data phase.
  assign bus.PWDATA = (bus.PWRITE && (|bus.PSEL)) ? bus.HWDATA : 32'h0;

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      state         <= ST_IDLE;
      slot_q        <= '0;
      bus.PSEL      <= '0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= 32'h0;
      bus.HRDATA    <= 32'h0;
      bus.HRESP     <= HRESP_OKAY;
      bus.HREADYOUT <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_RESP, ST_ERR2: begin
          if (capture) begin
            bus.PADDR     <= bus.HADDR;
            bus.PWRITE    <= bus.HWRITE;
            slot_q        <= slot_d;
            bus.PENABLE   <= 1'b0;
            bus.HREADYOUT <= 1'b0;
            if (slot_ok) begin
              state     <= ST_SETUP;
              bus.PSEL  <= psel_d;
              bus.HRESP <= HRESP_OKAY;
            end else begin
              state     <= ST_ERR1;
              bus.PSEL  <= '0;
              bus.HRESP <= HRESP_ERROR;
            end
          end else begin
            state         <= ST_IDLE;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= HRESP_OKAY;
          end
        end
        ST_SETUP: begin
          state       <= ST_ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (!bus.PWRITE) bus.HRDATA <= rdata_mux;
          state         <= ST_RESP;
          bus.PSEL      <= '0;
          bus.PENABLE   <= 1'b0;
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= HRESP_OKAY;
        end
        ST_ERR1: begin
          state         <= ST_ERR2;
          bus.HREADYOUT <= 1'b1;
        end
        default: begin
          state         <= ST_IDLE;
          bus.PSEL      <= '0;
          bus.PENABLE   <= 1'b0;
          bus.HREADYOUT <= 1'b1;
          bus.HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: a 4-slot bridge for the main transfers
// and a 3-slot bridge for the unmapped-slot ERROR response.
module tb_ahb2apb_bridge;
  import ahb_apb_pkg::*;

  logic HCLK;
  logic HRST_N;
  int   total;
  int   bad;

  ahb2apb_bridge_if #(.NSLV(4)) bus4 ();
  ahb2apb_bridge_if #(.NSLV(3)) bus3 ();

  assign bus4.HREADY = bus4.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  ahb2apb_bridge #(.NSLV(4), .SLV_LSB(12), .SLV_BITS(2)) u_dut4 (
    .HCLK   (HCLK),
    .HRST_N (HRST_N),
    .bus    (bus4.slave)
  );

  ahb2apb_bridge #(.NSLV(3), .SLV_LSB(12), .SLV_BITS(2)) u_dut3 (
    .HCLK   (HCLK),
    .HRST_N (HRST_N),
    .bus    (bus3.slave)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apply_stimulus(input logic sel, input logic [31:0] addr,
                                input logic [1:0] trans, input logic write);
    bus4.HSEL   = sel;
    bus4.HADDR  = addr;
    bus4.HTRANS = trans;
    bus4.HWRITE = write;
    #1;
  endtask

  task automatic bus_idle();
    apply_stimulus(1'b0, 32'h0, HTRANS_IDLE, 1'b0);
  endtask

  initial begin
    logic [1:0] pat_trans [3];
    logic       pat_sel   [3];
    total = 0;
    bad   = 0;
    HRST_N = 1'b0;
    bus4.HSEL = 1'b0; bus4.HADDR = '0; bus4.HTRANS = HTRANS_IDLE; bus4.HWRITE = 1'b0;
    bus4.HSIZE = 3'b010; bus4.HWDATA = '0; bus4.PRDATA = '0;
    bus3.HSEL = 1'b0; bus3.HADDR = '0; bus3.HTRANS = HTRANS_IDLE; bus3.HWRITE = 1'b0;
    bus3.HSIZE = 3'b010; bus3.HWDATA = '0; bus3.PRDATA = '0;

    next_cycle();
    next_cycle();
    $display("[TB] reset values");
    check_output("rst_psel",      bus4.PSEL,      4'b0000);
    check_output("rst_penable",   bus4.PENABLE,   1'b0);
    check_output("rst_pwrite",    bus4.PWRITE,    1'b0);
    check_output("rst_paddr",     bus4.PADDR,     32'h0);
    check_output("rst_hrdata",    bus4.HRDATA,    32'h0);
    check_output("rst_hresp",     bus4.HRESP,     2'b00);
    check_output("rst_hreadyout", bus4.HREADYOUT, 1'b1);
    #2 HRST_N = 1'b1;
    next_cycle();

    $display("[TB] single write to slot 1");
    apply_stimulus(1'b1, 32'h0000_1004, HTRANS_NONSEQ, 1'b1);
    next_cycle();
    bus4.HWDATA = 32'hA5A5_0001;
    bus_idle();
    check_output("w_setup_psel",    bus4.PSEL,      4'b0010);
    check_output("w_setup_penable", bus4.PENABLE,   1'b0);
    check_output("w_setup_pwdata",  bus4.PWDATA,    32'hA5A5_0001);
    check_output("w_setup_paddr",   bus4.PADDR,     32'h0000_1004);
    check_output("w_setup_pwrite",  bus4.PWRITE,    1'b1);
    check_output("w_setup_hready",  bus4.HREADYOUT, 1'b0);
    next_cycle();
    check_output("w_access_psel",    bus4.PSEL,      4'b0010);
    check_output("w_access_penable", bus4.PENABLE,   1'b1);
    check_output("w_access_pwdata",  bus4.PWDATA,    32'hA5A5_0001);
    check_output("w_access_paddr",   bus4.PADDR,     32'h0000_1004);
    check_output("w_access_hready",  bus4.HREADYOUT, 1'b0);
    next_cycle();
    check_output("w_resp_hready", bus4.HREADYOUT, 1'b1);
    check_output("w_resp_hresp",  bus4.HRESP,     2'b00);
    check_output("w_resp_psel",   bus4.PSEL,      4'b0000);
    check_output("w_resp_hrdata", bus4.HRDATA,    32'h0);
    next_cycle();

    $display("[TB] read of slot 2");
    bus4.PRDATA = {32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    apply_stimulus(1'b1, 32'h0000_2010, HTRANS_NONSEQ, 1'b0);
    next_cycle();
    bus_idle();
    check_output("r_setup_psel",   bus4.PSEL,   4'b0100);
    check_output("r_setup_pwrite", bus4.PWRITE, 1'b0);
    check_output("r_setup_paddr",  bus4.PADDR,  32'h0000_2010);
    next_cycle();
    check_output("r_access_penable", bus4.PENABLE, 1'b1);
    check_output("r_access_pwrite",  bus4.PWRITE,  1'b0);
    check_output("r_access_pwdata",  bus4.PWDATA,  32'h0);
    next_cycle();
    check_output("r_resp_hready", bus4.HREADYOUT, 1'b1);
    check_output("r_resp_hrdata", bus4.HRDATA,    32'hDEAD_BEEF);
    check_output("r_resp_pwrite", bus4.PWRITE,    1'b0);
    next_cycle();

    $display("[TB] back-to-back write slot 0 then read slot 3");
    bus4.PRDATA = {32'h0BAD_F00D, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    apply_stimulus(1'b1, 32'h0000_0008, HTRANS_NONSEQ, 1'b1);
    next_cycle();
    bus4.HWDATA = 32'h1234_5678;
    bus_idle();
    check_output("b2b_1_setup_psel",   bus4.PSEL,   4'b0001);
    check_output("b2b_1_setup_pwdata", bus4.PWDATA, 32'h1234_5678);
    next_cycle();
    check_output("b2b_1_access_psel",    bus4.PSEL,    4'b0001);
    check_output("b2b_1_access_penable", bus4.PENABLE, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 32'h0000_3000, HTRANS_NONSEQ, 1'b0);
    check_output("b2b_1_resp_hready", bus4.HREADYOUT, 1'b1);
    check_output("b2b_1_resp_psel",   bus4.PSEL,      4'b0000);
    check_output("b2b_1_resp_hrdata", bus4.HRDATA,    32'hDEAD_BEEF);
    next_cycle();
    bus_idle();
    check_output("b2b_2_setup_psel",    bus4.PSEL,      4'b1000);
    check_output("b2b_2_setup_penable", bus4.PENABLE,   1'b0);
    check_output("b2b_2_setup_hready",  bus4.HREADYOUT, 1'b0);
    check_output("b2b_2_setup_paddr",   bus4.PADDR,     32'h0000_3000);
    next_cycle();
    check_output("b2b_2_access_psel",    bus4.PSEL,    4'b1000);
    check_output("b2b_2_access_penable", bus4.PENABLE, 1'b1);
    next_cycle();
    check_output("b2b_2_resp_hready", bus4.HREADYOUT, 1'b1);
    check_output("b2b_2_resp_hrdata", bus4.HRDATA,    32'h0BAD_F00D);
    next_cycle();

    $display("[TB] ignored transfers");
    pat_sel   = '{1'b1, 1'b1, 1'b0};
    pat_trans = '{HTRANS_BUSY, HTRANS_IDLE, HTRANS_NONSEQ};
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(pat_sel[i], 32'h0000_1000, pat_trans[i], 1'b1);
      for (int c = 0; c < 2; c++) begin
        next_cycle();
        check_output($sformatf("ign%0d_c%0d_psel", i, c),   bus4.PSEL,      4'b0000);
        check_output($sformatf("ign%0d_c%0d_hready", i, c), bus4.HREADYOUT, 1'b1);
        check_output($sformatf("ign%0d_c%0d_hresp", i, c),  bus4.HRESP,     2'b00);
      end
    end
    bus_idle();
    next_cycle();

    $display("[TB] reset during write access");
    apply_stimulus(1'b1, 32'h0000_1100, HTRANS_NONSEQ, 1'b1);
    next_cycle();
    bus4.HWDATA = 32'hCAFE_0006;
    bus_idle();
    next_cycle();
    check_output("rstmid_access_penable", bus4.PENABLE, 1'b1);
    check_output("rstmid_access_psel",    bus4.PSEL,    4'b0010);
    #1 HRST_N = 1'b0;
    #1;
    check_output("rstmid_async_psel",    bus4.PSEL,    4'b0000);
    check_output("rstmid_async_penable", bus4.PENABLE, 1'b0);
    check_output("rstmid_async_hrdata",  bus4.HRDATA,  32'h0);
    next_cycle();
    #2 HRST_N = 1'b1;
    next_cycle();
    check_output("rstmid_after_hready", bus4.HREADYOUT, 1'b1);
    check_output("rstmid_after_hresp",  bus4.HRESP,     2'b00);
    bus4.PRDATA = {32'h0, 32'h0, 32'h5555_AAAA, 32'h0};
    apply_stimulus(1'b1, 32'h0000_1000, HTRANS_NONSEQ, 1'b0);
    next_cycle();
    bus_idle();
    check_output("rstmid_rd_setup_psel", bus4.PSEL, 4'b0010);
    next_cycle();
    next_cycle();
    check_output("rstmid_rd_hready", bus4.HREADYOUT, 1'b1);
    check_output("rstmid_rd_hrdata", bus4.HRDATA,    32'h5555_AAAA);

    $display("[TB] unmapped slot on 3-slot bridge");
    bus3.HSEL = 1'b1; bus3.HADDR = 32'h0000_3000; bus3.HTRANS = HTRANS_NONSEQ; bus3.HWRITE = 1'b0;
    next_cycle();
    bus3.HSEL = 1'b0; bus3.HTRANS = HTRANS_IDLE;
    #1;
    check_output("err1_psel",   bus3.PSEL,      3'b000);
    check_output("err1_hready", bus3.HREADYOUT, 1'b0);
    check_output("err1_hresp",  bus3.HRESP,     2'b01);
    next_cycle();
    check_output("err2_psel",   bus3.PSEL,      3'b000);
    check_output("err2_hready", bus3.HREADYOUT, 1'b1);
    check_output("err2_hresp",  bus3.HRESP,     2'b01);
    next_cycle();
    check_output("err_idle_hready", bus3.HREADYOUT, 1'b1);
    check_output("err_idle_hresp",  bus3.HRESP,     2'b00);
    check_output("err_idle_psel",   bus3.PSEL,      3'b000);
    bus3.HSEL = 1'b1; bus3.HADDR = 32'h0000_2000; bus3.HTRANS = HTRANS_NONSEQ;
    next_cycle();
    bus3.HSEL = 1'b0; bus3.HTRANS = HTRANS_IDLE;
    #1;
    check_output("slot2_n3_psel",  bus3.PSEL,  3'b100);
    check_output("slot2_n3_hresp", bus3.HRESP, 2'b00);
    next_cycle();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
